// File: rtl/bit_pattern_serializer_if.sv
// Handshake and serial-output bundle for bit_pattern_serializer.
// The pattern controller drives the master side; the serializer implements the slave side.
interface bit_pattern_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             serial_out;
    logic             out_valid;
    logic             done;

    modport master (
        output load,
        output data_in,
        input  ready,
        input  serial_out,
        input  out_valid,
        input  done
    );

    modport slave (
        input  load,
        input  data_in,
        output ready,
        output serial_out,
        output out_valid,
        output done
    );
endinterface

// File: rtl/bit_pattern_serializer.sv
// Parallel-to-serial stimulus source: one WIDTH-bit word per handshake, one bit per clock.
// Define SERIAL_PARITY_EN to append an even-parity bit after each word.
module bit_pattern_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic                      clock,
    input  logic                      reset,
    bit_pattern_serializer_if.slave   bus
);

    localparam int unsigned   CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CntOne  = CW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StParity
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             serial_q, serial_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] data_w;
    logic [WIDTH-1:0] data_rest;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    cnt_inc;
    logic             data_first;
    logic             shift_head;
    logic             last_bit;
    logic             ready;
    logic             accept;

`ifdef SERIAL_PARITY_EN
    logic parity_q, parity_d;
`endif

    assign data_w  = bus.data_in;
    assign cnt_inc = cnt_q + CntOne;

    // The first bit goes straight to serial_q on acceptance; the shift register holds the rest.
    assign data_first = MSB_FIRST ? data_w[WIDTH-1] : data_w[0];
    assign data_rest  = MSB_FIRST ? {data_w[WIDTH-2:0], 1'b0} : {1'b0, data_w[WIDTH-1:1]};
    assign shift_head = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign shift_next = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

    assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);

`ifdef SERIAL_PARITY_EN
    assign ready = (state_q == StIdle) || (state_q == StParity);
`else
    assign ready = (state_q == StIdle) || last_bit;
`endif

    assign accept = bus.load && ready;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        serial_d = serial_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
`ifdef SERIAL_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                serial_d = IDLE_LEVEL;
                valid_d  = 1'b0;
            end
            StShift: begin
                if (!last_bit) begin
                    serial_d = shift_head;
                    shift_d  = shift_next;
                    cnt_d    = cnt_inc;
`ifndef SERIAL_PARITY_EN
                    done_d   = (cnt_inc == LastCnt);
`endif
                end else begin
`ifdef SERIAL_PARITY_EN
                    state_d  = StParity;
                    serial_d = parity_q;
                    done_d   = 1'b1;
`else
                    state_d  = StIdle;
                    serial_d = IDLE_LEVEL;
                    valid_d  = 1'b0;
`endif
                end
            end
            StParity: begin
                state_d  = StIdle;
                serial_d = IDLE_LEVEL;
                valid_d  = 1'b0;
            end
            default: begin
                state_d  = StIdle;
                serial_d = IDLE_LEVEL;
                valid_d  = 1'b0;
            end
        endcase

        // Acceptance overrides the wind-down above, giving a zero-gap stream.
        if (accept) begin
            state_d  = StShift;
            serial_d = data_first;
            shift_d  = data_rest;
            cnt_d    = '0;
            valid_d  = 1'b1;
            done_d   = 1'b0;
`ifdef SERIAL_PARITY_EN
            parity_d = ^data_w;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            cnt_q    <= '0;
            serial_q <= IDLE_LEVEL;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            serial_q <= serial_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

`ifdef SERIAL_PARITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign bus.ready      = ready;
    assign bus.serial_out = serial_q;
    assign bus.out_valid  = valid_q;
    assign bus.done       = done_q;

endmodule
